// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the multicycle MIPS CPU: prioritises traps and
// interrupts, sequences EPC/Cause/Status writes into CP0, handles eret and issues PC redirects.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
    parameter logic [4:0]  STATUS_ADDR  = 5'd12,
    parameter logic [4:0]  CAUSE_ADDR   = 5'd13,
    parameter logic [4:0]  EPC_ADDR     = 5'd14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_sys,
    input  logic        req_brk,
    input  logic        req_teq,
    input  logic [5:0]  irq,
    input  logic        req_eret,
    input  logic [31:0] cur_pc,
    input  logic [31:0] status_in,
    input  logic [31:0] epc_in,
    input  logic        dp_we,
    input  logic [4:0]  dp_addr,
    input  logic [31:0] dp_wdata,
    output logic        cp0_we,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exc_taken,
    output logic [3:0]  exc_code
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        ER_STATUS,
        REDIR
    } state_t;

    localparam logic [3:0] CODE_INT = 4'd0;
    localparam logic [3:0] CODE_SYS = 4'd8;
    localparam logic [3:0] CODE_BRK = 4'd9;
    localparam logic [3:0] CODE_TEQ = 4'd13;

    state_t      state, state_next;
    logic [31:0] cap_pc;
    logic [31:0] cap_status;
    logic [31:0] cap_epc;
    logic        cap_is_exc;

    logic        gie;
    logic        sys_ok, brk_ok, teq_ok;
    logic [5:0]  irq_ok;
    logic        exc_any;
    logic        accept_exc, accept_eret;
    logic [3:0]  code_sel;

    // Eligibility is evaluated against the live Status so a held request is
    // re-judged every IDLE cycle, including the one right after a redirect.
    assign gie     = status_in[0];
    assign sys_ok  = gie & req_sys & status_in[1];
    assign brk_ok  = gie & req_brk & status_in[2];
    assign teq_ok  = gie & req_teq & status_in[3];
    assign irq_ok  = gie ? (irq & status_in[13:8]) : 6'b0;
    assign exc_any = sys_ok | brk_ok | teq_ok | (|irq_ok);

    assign accept_exc  = (state == IDLE) & exc_any;
    assign accept_eret = (state == IDLE) & req_eret & ~exc_any;

    always_comb begin
        code_sel = CODE_INT;
        if (sys_ok)      code_sel = CODE_SYS;
        else if (brk_ok) code_sel = CODE_BRK;
        else if (teq_ok) code_sel = CODE_TEQ;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_pc     <= '0;
            cap_status <= '0;
            cap_epc    <= '0;
            cap_is_exc <= 1'b0;
            exc_code   <= '0;
        end else if (accept_exc) begin
            cap_pc     <= cur_pc;
            cap_status <= status_in;
            cap_is_exc <= 1'b1;
            exc_code   <= code_sel;
        end else if (accept_eret) begin
            cap_status <= status_in;
            cap_epc    <= epc_in;
            cap_is_exc <= 1'b0;
        end
    end

    // NOTE: every combinational output gets a default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_exc)       state_next = W_EPC;
                else if (accept_eret) state_next = ER_STATUS;
            end
            W_EPC:     state_next = W_CAUSE;
            W_CAUSE:   state_next = W_STATUS;
            W_STATUS:  state_next = REDIR;
            ER_STATUS: state_next = REDIR;
            REDIR:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        cp0_we         = 1'b0;
        cp0_waddr      = '0;
        cp0_wdata      = '0;
        busy           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exc_taken      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // Reset only parks the FSM in IDLE, so the input paths are gated
                // here to keep the outputs quiet while rst is held.
                if (!rst) begin
                    busy = accept_exc | accept_eret;
                    if (!busy) begin
                        cp0_we    = dp_we;
                        cp0_waddr = dp_addr;
                        cp0_wdata = dp_wdata;
                    end
                end
            end
            W_EPC: begin
                cp0_we    = 1'b1;
                cp0_waddr = EPC_ADDR;
                cp0_wdata = cap_pc;
            end
            W_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_waddr = CAUSE_ADDR;
                cp0_wdata = {26'b0, exc_code, 2'b0};
            end
            W_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = STATUS_ADDR;
                cp0_wdata = cap_status << 5;
            end
            ER_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = STATUS_ADDR;
                cp0_wdata = cap_status >> 5;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = cap_is_exc ? HANDLER_ADDR : cap_epc;
                exc_taken      = cap_is_exc;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a scoreboard queues the expected CP0 writes and
// redirects as stimulus is applied; a negedge monitor pops and compares them.
module tb_exc_ctrl;

    localparam logic [31:0] HANDLER = 32'h00400004;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_sys, req_brk, req_teq, req_eret;
    logic [5:0]  irq;
    logic [31:0] cur_pc, status_in, epc_in;
    logic        dp_we;
    logic [4:0]  dp_addr;
    logic [31:0] dp_wdata;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        busy, redirect_valid, exc_taken;
    logic [31:0] redirect_pc;
    logic [3:0]  exc_code;

    int n_assert = 0;
    int n_fail   = 0;

    wr_t wr_q[$];
    rd_t rd_q[$];

    exc_ctrl dut (
        .clk(clk), .rst(rst),
        .req_sys(req_sys), .req_brk(req_brk), .req_teq(req_teq),
        .irq(irq), .req_eret(req_eret),
        .cur_pc(cur_pc), .status_in(status_in), .epc_in(epc_in),
        .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_taken(exc_taken), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_sys  = 1'b0;
        req_brk  = 1'b0;
        req_teq  = 1'b0;
        req_eret = 1'b0;
        irq      = 6'b0;
        dp_we    = 1'b0;
    endtask

    task automatic push_exc(input logic [31:0] pc, input logic [31:0] st, input logic [3:0] code);
        wr_q.push_back('{addr: 5'd14, data: pc});
        wr_q.push_back('{addr: 5'd13, data: {26'b0, code, 2'b0}});
        wr_q.push_back('{addr: 5'd12, data: st << 5});
        rd_q.push_back('{pc: HANDLER, taken: 1'b1});
    endtask

    // Caller has already driven the request; this walks the full exception sequence.
    task automatic run_exc(input string tag, input logic [31:0] pc, input logic [31:0] st,
                           input logic [3:0] code);
        push_exc(pc, st, code);
        @(negedge clk);
        check({tag, "_busy_accept"}, {31'b0, busy}, 32'd1);
        tick();
        clear_reqs();
        repeat (4) begin
            @(negedge clk);
            check({tag, "_busy_seq"}, {31'b0, busy}, 32'd1);
            tick();
        end
        @(negedge clk);
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_exc_code"}, {28'b0, exc_code}, {28'b0, code});
    endtask

    // Scoreboard monitor: every CP0 write and redirect must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (cp0_we) begin
                check("cp0_write_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("cp0_waddr", {27'b0, cp0_waddr}, {27'b0, e.addr});
                    check("cp0_wdata", cp0_wdata, e.data);
                end
            end
            if (redirect_valid) begin
                check("redirect_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check("redirect_pc", redirect_pc, r.pc);
                    check("exc_taken", {31'b0, exc_taken}, {31'b0, r.taken});
                end
            end else begin
                check("exc_taken_idle", {31'b0, exc_taken}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        clear_reqs();
        cur_pc    = 32'h0;
        status_in = 32'h0;
        epc_in    = 32'h0;
        dp_addr   = 5'd0;
        dp_wdata  = 32'h0;

        // Reset: outputs quiet even with a datapath write presented.
        dp_we    = 1'b1;
        dp_addr  = 5'd12;
        dp_wdata = 32'h12345678;
        @(negedge clk);
        check("rst_cp0_we", {31'b0, cp0_we}, 32'd0);
        check("rst_cp0_waddr", {27'b0, cp0_waddr}, 32'd0);
        check("rst_cp0_wdata", cp0_wdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_redirect", {31'b0, redirect_valid}, 32'd0);
        check("rst_exc_code", {28'b0, exc_code}, 32'd0);
        tick();
        rst = 1'b0;
        dp_we = 1'b0;

        // Syscall.
        status_in = 32'h0000000F;
        cur_pc    = 32'h00400100;
        req_sys   = 1'b1;
        run_exc("sys", 32'h00400100, 32'h0000000F, 4'd8);

        // Masked break with concurrent datapath mtc0.
        tick();
        status_in = 32'h00000001;
        req_brk   = 1'b1;
        dp_we     = 1'b1;
        dp_addr   = 5'd12;
        dp_wdata  = 32'hDEADBEEF;
        wr_q.push_back('{addr: 5'd12, data: 32'hDEADBEEF});
        @(negedge clk);
        check("mbrk_busy", {31'b0, busy}, 32'd0);
        check("mbrk_pass_we", {31'b0, cp0_we}, 32'd1);
        tick();
        clear_reqs();
        repeat (2) begin
            @(negedge clk);
            check("mbrk_busy_after", {31'b0, busy}, 32'd0);
            tick();
        end

        // Everything at once: syscall wins, dp write dropped.
        status_in = 32'h0000010F;
        cur_pc    = 32'h00400180;
        req_sys   = 1'b1;
        req_teq   = 1'b1;
        irq       = 6'b000001;
        req_eret  = 1'b1;
        dp_we     = 1'b1;
        dp_addr   = 5'd3;
        dp_wdata  = 32'h55555555;
        run_exc("simul", 32'h00400180, 32'h0000010F, 4'd8);

        // Interrupt on line 2.
        tick();
        status_in = 32'h00000401;
        cur_pc    = 32'h00400300;
        irq       = 6'b000100;
        run_exc("irq2", 32'h00400300, 32'h00000401, 4'd0);

        // teq outranks an enabled interrupt.
        tick();
        status_in = 32'h00000809;
        cur_pc    = 32'h00400340;
        req_teq   = 1'b1;
        irq       = 6'b001000;
        run_exc("teq", 32'h00400340, 32'h00000809, 4'd13);

        // eret.
        tick();
        status_in = 32'h000001E0;
        epc_in    = 32'h00400200;
        req_eret  = 1'b1;
        wr_q.push_back('{addr: 5'd12, data: 32'h0000000F});
        rd_q.push_back('{pc: 32'h00400200, taken: 1'b0});
        @(negedge clk);
        check("eret_busy_accept", {31'b0, busy}, 32'd1);
        tick();
        clear_reqs();
        repeat (2) begin
            @(negedge clk);
            check("eret_busy_seq", {31'b0, busy}, 32'd1);
            tick();
        end
        @(negedge clk);
        check("eret_busy_done", {31'b0, busy}, 32'd0);
        check("eret_exc_code_kept", {28'b0, exc_code}, 32'd13);

        // Back-to-back: held break is re-accepted against the updated Status.
        tick();
        status_in = 32'h00000005;
        cur_pc    = 32'h00400500;
        req_brk   = 1'b1;
        push_exc(32'h00400500, 32'h00000005, 4'd9);
        @(negedge clk);
        check("b2b_busy_accept1", {31'b0, busy}, 32'd1);
        tick();
        tick();
        tick();
        status_in = 32'h0000000D;
        cur_pc    = 32'h00400600;
        tick();
        @(negedge clk);
        check("b2b_busy_redir", {31'b0, busy}, 32'd1);
        tick();
        run_exc("b2b2", 32'h00400600, 32'h0000000D, 4'd9);

        // Reset during W_CAUSE aborts the sequence.
        tick();
        status_in = 32'h0000000F;
        cur_pc    = 32'h00400400;
        req_sys   = 1'b1;
        wr_q.push_back('{addr: 5'd14, data: 32'h00400400});
        @(negedge clk);
        check("rstmid_busy_accept", {31'b0, busy}, 32'd1);
        tick();
        clear_reqs();
        @(negedge clk);
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_cp0_we", {31'b0, cp0_we}, 32'd0);
        check("rstmid_cp0_waddr", {27'b0, cp0_waddr}, 32'd0);
        check("rstmid_cp0_wdata", cp0_wdata, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_redirect", {31'b0, redirect_valid}, 32'd0);
        check("rstmid_redirect_pc", redirect_pc, 32'd0);
        check("rstmid_exc_taken", {31'b0, exc_taken}, 32'd0);
        check("rstmid_exc_code", {28'b0, exc_code}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rstmid_idle", {31'b0, busy}, 32'd0);
            tick();
        end

        check("writes_left", 32'(wr_q.size()), 32'd0);
        check("redirects_left", 32'(rd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
